// File: rtl/control_unit_if.sv
// control_unit_if -- handshake bundle between the LC-3 control FSM and its datapath.
//   Inputs to the FSM : Run, Continue (pushbuttons), Opcode/IR_5/IR_11 (instruction
//                       register fields), BEN (registered branch-enable flag).
//   Outputs of the FSM: register load enables, bus gates, mux selects,
//                       ALU function and memory strobes.
//   slave  modport: the control unit itself.
//   master modport: the datapath / environment that drives the inputs.
interface control_unit_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic       Mem_OE, Mem_WE;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;

    modport slave (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
               GatePC, GateMDR, GateALU, GateMARMUX,
               DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE,
               PCMUX, ADDR2MUX, ALUK
    );

    modport master (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
               GatePC, GateMDR, GateALU, GateMARMUX,
               DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE,
               PCMUX, ADDR2MUX, ALUK
    );
endinterface

// File: rtl/control_unit.sv
// control_unit -- Moore FSM sequencing fetch / decode / execute for a small LC-3
// subset (ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR, PAUSE).
//   Clk   : sole clock, rising edge.
//   Reset : synchronous active-high, forces HALTED from any state.
//   cu    : control_unit_if.slave -- pushbuttons, IR fields and BEN in;
//           load enables, gates, mux selects, ALUK, memory strobes out.
// Outputs depend on the state register only (plus the IR_5 / IR_11 fields,
// which come from the registered IR), so they are glitch-free per cycle.
module control_unit (
    input  logic            Clk,
    input  logic            Reset,
    control_unit_if.slave   cu
);

    typedef enum logic [4:0] {
        HALTED, S18, S33_1, S33_2, S33_3, S35, S32,
        S1, S5, S9, S0, S22, S12, S4, S21,
        S6, S25_1, S25_2, S25_3, S27,
        S7, S23, S16_1, S16_2, S16_3,
        PAUSE1, PAUSE2
    } state_t;

    state_t state, next;

    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic       mem_oe, mem_we;
    logic [1:0] pcmux, addr2mux, aluk;

    always_ff @(posedge Clk) begin
        if (Reset) state <= HALTED;
        else       state <= next;
    end

    always_comb begin
        next        = state;
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_ir       = 1'b0;
        ld_ben      = 1'b0;
        ld_cc       = 1'b0;
        ld_reg      = 1'b0;
        ld_pc       = 1'b0;
        gate_pc     = 1'b0;
        gate_mdr    = 1'b0;
        gate_alu    = 1'b0;
        gate_marmux = 1'b0;
        drmux       = 1'b0;
        sr1mux      = 1'b0;
        sr2mux      = 1'b0;
        addr1mux    = 1'b0;
        mem_oe      = 1'b0;
        mem_we      = 1'b0;
        pcmux       = 2'b00;
        addr2mux    = 2'b00;
        aluk        = 2'b00;

        case (state)
            HALTED: if (cu.Run) next = S18;

            // Fetch: MAR <- PC, PC <- PC+1
            S18: begin
                ld_mar  = 1'b1;
                gate_pc = 1'b1;
                ld_pc   = 1'b1;
                pcmux   = 2'b00;
                next    = S33_1;
            end
            // Three-cycle memory read; MDR captures on the last one
            S33_1: begin mem_oe = 1'b1; next = S33_2; end
            S33_2: begin mem_oe = 1'b1; next = S33_3; end
            S33_3: begin mem_oe = 1'b1; ld_mdr = 1'b1; next = S35; end
            S35: begin
                gate_mdr = 1'b1;
                ld_ir    = 1'b1;
                next     = S32;
            end
            S32: begin
                ld_ben = 1'b1;
                case (cu.Opcode)
                    4'b0001: next = S1;
                    4'b0101: next = S5;
                    4'b1001: next = S9;
                    4'b0000: next = S0;
                    4'b1100: next = S12;
                    4'b0100: next = S4;
                    4'b0110: next = S6;
                    4'b0111: next = S7;
                    4'b1101: next = PAUSE1;
                    default: next = S18;
                endcase
            end

            // ALU ops share everything except the function select
            S1, S5, S9: begin
                gate_alu = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                sr1mux   = 1'b1;
                sr2mux   = cu.IR_5;
                aluk     = (state == S1) ? 2'b00 : (state == S5) ? 2'b01 : 2'b10;
                next     = S18;
            end

            // BEN was loaded in S32, so it is valid here
            S0: next = cu.BEN ? S22 : S18;
            S22: begin
                ld_pc    = 1'b1;
                pcmux    = 2'b10;
                addr2mux = 2'b10;
                next     = S18;
            end
            S12: begin
                ld_pc    = 1'b1;
                pcmux    = 2'b10;
                addr1mux = 1'b1;
                sr1mux   = 1'b1;
                next     = S18;
            end

            // JSR/JSRR: R7 <- PC, then PC <- target
            S4: begin
                gate_pc = 1'b1;
                ld_reg  = 1'b1;
                drmux   = 1'b1;
                next    = S21;
            end
            S21: begin
                ld_pc = 1'b1;
                pcmux = 2'b10;
                if (cu.IR_11) begin
                    addr2mux = 2'b11;
                end else begin
                    addr1mux = 1'b1;
                    sr1mux   = 1'b1;
                end
                next = S18;
            end

            // LDR / STR effective address: MAR <- BaseR + off6
            S6, S7: begin
                gate_marmux = 1'b1;
                ld_mar      = 1'b1;
                addr1mux    = 1'b1;
                sr1mux      = 1'b1;
                addr2mux    = 2'b01;
                next        = (state == S6) ? S25_1 : S23;
            end
            S25_1: begin mem_oe = 1'b1; next = S25_2; end
            S25_2: begin mem_oe = 1'b1; next = S25_3; end
            S25_3: begin mem_oe = 1'b1; ld_mdr = 1'b1; next = S27; end
            S27: begin
                gate_mdr = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                next     = S18;
            end
            // STR: SR (IR[11:9]) passes through the ALU into MDR
            S23: begin
                gate_alu = 1'b1;
                ld_mdr   = 1'b1;
                aluk     = 2'b11;
                sr1mux   = 1'b0;
                next     = S16_1;
            end
            S16_1: begin mem_we = 1'b1; next = S16_2; end
            S16_2: begin mem_we = 1'b1; next = S16_3; end
            S16_3: begin mem_we = 1'b1; next = S18; end

            // Wait for press, then for release, so one press resumes once
            PAUSE1: if (cu.Continue)  next = PAUSE2;
            PAUSE2: if (!cu.Continue) next = S18;

            default: next = HALTED;
        endcase
    end

    assign cu.LD_MAR     = ld_mar;
    assign cu.LD_MDR     = ld_mdr;
    assign cu.LD_IR      = ld_ir;
    assign cu.LD_BEN     = ld_ben;
    assign cu.LD_CC      = ld_cc;
    assign cu.LD_REG     = ld_reg;
    assign cu.LD_PC      = ld_pc;
    assign cu.GatePC     = gate_pc;
    assign cu.GateMDR    = gate_mdr;
    assign cu.GateALU    = gate_alu;
    assign cu.GateMARMUX = gate_marmux;
    assign cu.DRMUX      = drmux;
    assign cu.SR1MUX     = sr1mux;
    assign cu.SR2MUX     = sr2mux;
    assign cu.ADDR1MUX   = addr1mux;
    assign cu.Mem_OE     = mem_oe;
    assign cu.Mem_WE     = mem_we;
    assign cu.PCMUX      = pcmux;
    assign cu.ADDR2MUX   = addr2mux;
    assign cu.ALUK       = aluk;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- builds a per-cycle expected trace of control words from the
// instruction-level description of each opcode, then steps the DUT through it.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_unit_if cu ();
    control_unit dut (.Clk(clk), .Reset(rst), .cu(cu.slave));

    // Control word layout: {LD_MAR..Mem_WE, PCMUX, ADDR2MUX, ALUK}
    localparam logic [22:0] LD_MAR   = 23'd1 << 22;
    localparam logic [22:0] LD_MDR   = 23'd1 << 21;
    localparam logic [22:0] LD_IR    = 23'd1 << 20;
    localparam logic [22:0] LD_BEN   = 23'd1 << 19;
    localparam logic [22:0] LD_CC    = 23'd1 << 18;
    localparam logic [22:0] LD_REG   = 23'd1 << 17;
    localparam logic [22:0] LD_PC    = 23'd1 << 16;
    localparam logic [22:0] G_PC     = 23'd1 << 15;
    localparam logic [22:0] G_MDR    = 23'd1 << 14;
    localparam logic [22:0] G_ALU    = 23'd1 << 13;
    localparam logic [22:0] G_MARMUX = 23'd1 << 12;
    localparam logic [22:0] DRMUX    = 23'd1 << 11;
    localparam logic [22:0] SR1MUX   = 23'd1 << 10;
    localparam logic [22:0] SR2MUX   = 23'd1 << 9;
    localparam logic [22:0] ADDR1MUX = 23'd1 << 8;
    localparam logic [22:0] MEM_OE   = 23'd1 << 7;
    localparam logic [22:0] MEM_WE   = 23'd1 << 6;
    localparam logic [22:0] PC_ADDER = 23'd2 << 4;
    localparam logic [22:0] A2_OFF6  = 23'd1 << 2;
    localparam logic [22:0] A2_OFF9  = 23'd2 << 2;
    localparam logic [22:0] A2_OFF11 = 23'd3 << 2;
    localparam logic [22:0] K_AND    = 23'd1;
    localparam logic [22:0] K_NOT    = 23'd2;
    localparam logic [22:0] K_PASSA  = 23'd3;

    // run_m / cont_m: 0 or 1 drive that value, 2 drive random (must be ignored)
    typedef struct {
        logic [22:0] exp;
        int          run_m;
        int          cont_m;
        logic        rst;
        logic [3:0]  op;
        logic        ir5, ir11, ben;
        string       tag;
    } ent_t;

    ent_t q[$];
    logic [3:0] cur_op;
    logic       cur_ir5, cur_ir11, cur_ben;
    int checks = 0;
    int failures = 0;

    function automatic logic [22:0] observed();
        return {cu.LD_MAR, cu.LD_MDR, cu.LD_IR, cu.LD_BEN, cu.LD_CC, cu.LD_REG, cu.LD_PC,
                cu.GatePC, cu.GateMDR, cu.GateALU, cu.GateMARMUX,
                cu.DRMUX, cu.SR1MUX, cu.SR2MUX, cu.ADDR1MUX, cu.Mem_OE, cu.Mem_WE,
                cu.PCMUX, cu.ADDR2MUX, cu.ALUK};
    endfunction

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [22:0] e, input int rm, input int cm,
                       input logic r, input string tag);
        ent_t x;
        x.exp = e; x.run_m = rm; x.cont_m = cm; x.rst = r;
        x.op = cur_op; x.ir5 = cur_ir5; x.ir11 = cur_ir11; x.ben = cur_ben;
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic set_instr(input logic [3:0] op, input logic i5, input logic i11, input logic b);
        cur_op = op; cur_ir5 = i5; cur_ir11 = i11; cur_ben = b;
    endtask

    task automatic push_fetch();
        add(LD_MAR | G_PC | LD_PC, 2, 2, 1'b0, "fetch_s18");
        add(MEM_OE,                2, 2, 1'b0, "fetch_rd1");
        add(MEM_OE,                2, 2, 1'b0, "fetch_rd2");
        add(MEM_OE | LD_MDR,       2, 2, 1'b0, "fetch_rd3");
        add(G_MDR | LD_IR,         2, 2, 1'b0, "fetch_ld_ir");
        add(LD_BEN,                2, 2, 1'b0, "decode_ld_ben");
    endtask

    // Execute phase of one instruction, as seen on the control outputs.
    task automatic push_exec(input int pk, input int pm);
        logic [22:0] alu, ea;
        alu = G_ALU | LD_REG | LD_CC | SR1MUX | (cur_ir5 ? SR2MUX : 23'd0);
        ea  = G_MARMUX | LD_MAR | ADDR1MUX | SR1MUX | A2_OFF6;
        case (cur_op)
            4'b0001: add(alu,         2, 2, 1'b0, "add");
            4'b0101: add(alu | K_AND, 2, 2, 1'b0, "and");
            4'b1001: add(alu | K_NOT, 2, 2, 1'b0, "not");
            4'b0000: begin
                add(23'd0, 2, 2, 1'b0, "br_test");
                if (cur_ben) add(LD_PC | PC_ADDER | A2_OFF9, 2, 2, 1'b0, "br_taken");
            end
            4'b1100: add(LD_PC | PC_ADDER | ADDR1MUX | SR1MUX, 2, 2, 1'b0, "jmp");
            4'b0100: begin
                add(G_PC | LD_REG | DRMUX, 2, 2, 1'b0, "jsr_link");
                if (cur_ir11) add(LD_PC | PC_ADDER | A2_OFF11, 2, 2, 1'b0, "jsr_target");
                else          add(LD_PC | PC_ADDER | ADDR1MUX | SR1MUX, 2, 2, 1'b0, "jsrr_target");
            end
            4'b0110: begin
                add(ea,              2, 2, 1'b0, "ldr_ea");
                add(MEM_OE,          2, 2, 1'b0, "ldr_rd1");
                add(MEM_OE,          2, 2, 1'b0, "ldr_rd2");
                add(MEM_OE | LD_MDR, 2, 2, 1'b0, "ldr_rd3");
                add(G_MDR | LD_REG | LD_CC, 2, 2, 1'b0, "ldr_wb");
            end
            4'b0111: begin
                add(ea, 2, 2, 1'b0, "str_ea");
                add(G_ALU | LD_MDR | K_PASSA, 2, 2, 1'b0, "str_mdr");
                for (int i = 0; i < 3; i++) add(MEM_WE, 2, 2, 1'b0, "str_wr");
            end
            4'b1101: begin
                // pk cycles waiting for the press, pm cycles waiting for release
                for (int i = 0; i < pk; i++) add(23'd0, 2, (i == pk-1) ? 1 : 0, 1'b0, "pause_wait");
                for (int i = 0; i < pm; i++) add(23'd0, 2, (i == pm-1) ? 0 : 1, 1'b0, "pause_held");
            end
            default: ;
        endcase
    endtask

    task automatic push_instr(input logic [3:0] op, input logic i5, input logic i11,
                              input logic b, input int pk, input int pm);
        set_instr(op, i5, i11, b);
        push_fetch();
        push_exec(pk, pm);
    endtask

    task automatic run_q();
        ent_t e;
        logic [22:0] got;
        while (q.size() > 0) begin
            e = q.pop_front();
            rst         = e.rst;
            cu.Run      = (e.run_m == 2)  ? 1'($urandom % 2) : 1'(e.run_m);
            cu.Continue = (e.cont_m == 2) ? 1'($urandom % 2) : 1'(e.cont_m);
            cu.Opcode   = e.op;
            cu.IR_5     = e.ir5;
            cu.IR_11    = e.ir11;
            cu.BEN      = e.ben;
            #1;
            got = observed();
            chk(e.tag, got, e.exp);
            chk("oe_we_exclusive", {22'd0, got[7] & got[6]}, 23'd0);
            chk("gates_onehot0", 23'($countones(got[15:12]) > 1), 23'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        cu.Run = 1'b0; cu.Continue = 1'b0; cu.Opcode = 4'd0;
        cu.IR_5 = 1'b0; cu.IR_11 = 1'b0; cu.BEN = 1'b0;
        set_instr(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Reset state and HALTED hold (Run high under reset must not start)
        add(23'd0, 1, 1, 1'b1, "reset_state");
        add(23'd0, 0, 2, 1'b0, "halted_hold");
        add(23'd0, 0, 2, 1'b0, "halted_hold");
        add(23'd0, 1, 2, 1'b0, "halted_go");

        // Directed instructions
        push_instr(4'b0001, 1'b1, 1'b0, 1'b0, 1, 1);
        push_instr(4'b0000, 1'b0, 1'b0, 1'b1, 1, 1);
        push_instr(4'b0000, 1'b0, 1'b0, 1'b0, 1, 1);
        push_instr(4'b0111, 1'b1, 1'b1, 1'b1, 1, 1);
        push_instr(4'b1101, 1'b0, 1'b0, 1'b0, 10, 5);
        push_instr(4'b0100, 1'b0, 1'b1, 1'b0, 1, 1);
        push_instr(4'b0100, 1'b1, 1'b0, 1'b0, 1, 1);
        push_instr(4'b1111, 1'b0, 1'b0, 1'b0, 1, 1);
        push_instr(4'b1100, 1'b0, 1'b0, 1'b0, 1, 1);
        run_q();

        // Random instruction stream
        for (int n = 0; n < 40; n++)
            push_instr(4'($urandom_range(0, 15)), 1'($urandom % 2), 1'($urandom % 2),
                       1'($urandom % 2), $urandom_range(1, 4), $urandom_range(1, 4));
        run_q();

        // Reset during the LDR memory wait, with Run and Continue also high
        set_instr(4'b0110, 1'b0, 1'b0, 1'b0);
        push_fetch();
        add(G_MARMUX | LD_MAR | ADDR1MUX | SR1MUX | A2_OFF6, 2, 2, 1'b0, "ldr_ea");
        add(MEM_OE, 2, 2, 1'b0, "ldr_rd1");
        add(MEM_OE, 1, 1, 1'b1, "ldr_rd2_reset");
        add(23'd0,  0, 2, 1'b0, "halted_after_reset");
        add(23'd0,  1, 2, 1'b0, "halted_restart");
        push_instr(4'b0101, 1'b0, 1'b0, 1'b0, 1, 1);

        // Reset while paused
        set_instr(4'b1101, 1'b0, 1'b0, 1'b0);
        push_fetch();
        add(23'd0, 2, 0, 1'b0, "pause_wait");
        add(23'd0, 2, 1, 1'b1, "pause_reset");
        add(23'd0, 0, 1, 1'b0, "halted_after_pause_reset");
        add(23'd0, 1, 2, 1'b0, "halted_restart");
        push_instr(4'b1001, 1'b1, 1'b0, 1'b0, 1, 1);
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL provide these ports: Clk, input, 1, sole clock, all state changes on rising edge.
REQ-002 The block SHALL provide these ports: Reset, input, 1, synchronous active-high reset.
REQ-003 The block SHALL provide these ports: Run, Continue, input, 1 each, start and pause-release pushbuttons, active-high and synchronised upstream.
REQ-004 The block SHALL provide these ports: Opcode, input, 4, IR[15:12]; IR_5, input, 1, immediate select; IR_11, input, 1, JSR/JSRR select; BEN, input, 1, registered branch-enable flag.
REQ-005 The block SHALL provide these outputs, 1 bit each: LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE.
REQ-006 The block SHALL provide these outputs, 2 bits each: PCMUX (00 PC+1, 01 bus, 10 adder), ADDR2MUX (00 zero, 01 off6, 10 off9, 11 off11), ALUK (00 ADD, 01 AND, 10 NOT, 11 PASSA).

Function
REQ-007 Outputs SHALL be a Moore function of the state register only: all 0 except the signals listed for the current state; DRMUX 0 selects IR[11:9] and 1 selects R7; SR1MUX 0 selects IR[11:9] and 1 selects IR[8:6]; ADDR1MUX 0 selects PC and 1 selects SR1.
REQ-008 HALTED: stay while Run=0; go to S18 when Run=1.
REQ-009 S18: LD_MAR, GatePC, LD_PC, PCMUX=00; then S33_1.
REQ-010 S33_1, S33_2: Mem_OE; S33_3: Mem_OE, LD_MDR; sequence S33_1, S33_2, S33_3, S35, one state per cycle.
REQ-011 S35: GateMDR, LD_IR; then S32.
REQ-012 S32: LD_BEN; dispatch on Opcode: 0001 S1, 0101 S5, 1001 S9, 0000 S0, 1100 S12, 0100 S4, 0110 S6, 0111 S7, 1101 PAUSE1; every other opcode to S18.
REQ-013 S1 (ADD), S5 (AND), S9 (NOT): GateALU, LD_REG, LD_CC, SR1MUX=1, SR2MUX=IR_5, ALUK 00/01/10 respectively; then S18.
REQ-014 S0: no asserted outputs; go to S22 if BEN=1, else S18. BEN SHALL be sampled in S0, one cycle after the S32 load.
REQ-015 S22: LD_PC, PCMUX=10, ADDR1MUX=0, ADDR2MUX=10; then S18.
REQ-016 S12 (JMP): LD_PC, PCMUX=10, ADDR1MUX=1, SR1MUX=1, ADDR2MUX=00; then S18.
REQ-017 S4: GatePC, LD_REG, DRMUX=1; then S21. S21: LD_PC, PCMUX=10; IR_11=1 gives ADDR1MUX=0, ADDR2MUX=11; IR_11=0 gives ADDR1MUX=1, SR1MUX=1, ADDR2MUX=00; then S18.
REQ-018 S6: GateMARMUX, LD_MAR, ADDR1MUX=1, SR1MUX=1, ADDR2MUX=01; then S25_1. S25_1 through S25_3 behave as S33_1 through S33_3; then S27. S27: GateMDR, LD_REG, LD_CC; then S18.
REQ-019 S7: same outputs as S6; then S23. S23: GateALU, LD_MDR, ALUK=11, SR1MUX=0; then S16_1. S16_1 through S16_3: Mem_WE; then S18.
REQ-020 PAUSE1: hold while Continue=0; go to PAUSE2 on Continue=1. PAUSE2: hold while Continue=1; go to S18 on Continue=0, so one press equals one resume.
REQ-021 Run SHALL be ignored outside HALTED. Continue SHALL be ignored outside PAUSE1 and PAUSE2.
REQ-022 Mem_WE and Mem_OE SHALL never be high in the same cycle. No two Gate* outputs SHALL be high in the same cycle.

Reset
REQ-023 Reset=1 at a clock edge SHALL force HALTED from any state, including mid-memory-wait and PAUSE. Reset SHALL take priority over Run and Continue.
REQ-024 While in HALTED, all outputs SHALL be 0.

Verification
REQ-025 Reset, then Run=1 for one cycle: S18, S33_1, S33_2, S33_3, S35, S32. LD_IR is high exactly in cycle 5; LD_BEN is high in cycle 6.
REQ-026 Opcode=0001, IR_5=1 after fetch: the cycle after S32 shows GateALU=1, LD_REG=1, LD_CC=1, SR2MUX=1, ALUK=00; the next state is S18.
REQ-027 Opcode=0000 with BEN=1: S0 then S22 with LD_PC=1, PCMUX=10, ADDR2MUX=10. Repeat with BEN=0: S0 then S18, and LD_PC is never asserted.
REQ-028 Opcode=0111: S7, S23, then exactly 3 cycles with Mem_WE=1, then S18. Mem_OE stays 0 throughout.
REQ-029 Opcode=1101: the FSM holds in PAUSE1 for 10 cycles, Continue=1 for 5 cycles holds PAUSE2, and Continue=0 leads to S18 next.
REQ-030 Reset asserted during S25_2: next state is HALTED with all outputs 0, and Run=1 restarts at S18.
